// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_queue
//  Description : Instruction queue between fetch and decode. Buffers
//                (instruction, pc) pairs in FIFO order and presents the
//                oldest entry to the decoder. Contents are discarded on a
//                pipeline flush.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rdy                 - global ready; low freezes all state
//                flush               - discard every queued entry
//                fetch_valid/inst/pc - push side from the fetcher
//                fetch_full          - queue full, fetcher must not push
//                queue_is_empty      - no valid head entry
//                queue_inst/pc       - head entry (0 when empty)
//                decode_enable       - decoder pops the head entry
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_inst,
    input  logic [31:0] fetch_pc,
    output logic        fetch_full,
    output logic        queue_is_empty,
    output logic [31:0] queue_inst,
    output logic [31:0] queue_pc,
    input  logic        decode_enable
);

    localparam logic [ADDR_W:0]   c_full_count = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_cnt_one    = (ADDR_W + 1)'(1);

    // Each entry keeps inst in the upper half and pc in the lower half so the
    // pair can never be separated.
    logic [63:0]       r_mem [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [63:0]       w_head_entry;

    // Fullness is judged on the registered count only, so a same-cycle pop
    // never makes room for a push.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_full_count);
    assign w_push  = fetch_valid & ~w_full;
    assign w_pop   = decode_enable & ~w_empty;

    // Storage is not reset; masking on empty keeps stale data invisible.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !flush && w_push) begin
            r_mem[r_tail] <= {fetch_inst, fetch_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + c_ptr_one;
                end
                if (w_pop) begin
                    r_head <= r_head + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head_entry   = r_mem[r_head];
    assign fetch_full     = w_full;
    assign queue_is_empty = w_empty;
    assign queue_inst     = w_empty ? 32'd0 : w_head_entry[63:32];
    assign queue_pc       = w_empty ? 32'd0 : w_head_entry[31:0];

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_queue
//  Description : Self-checking bench for inst_queue. Directed steps follow
//                the queue's use cases, then a randomized phase; every step
//                is checked against a FIFO reference model built on a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_inst = '0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_full;
    logic        queue_is_empty;
    logic [31:0] queue_inst;
    logic [31:0] queue_pc;
    logic        decode_enable = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: oldest entry at index 0, {inst, pc}.
    logic [63:0] model_q[$];

    inst_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .flush          (flush),
        .fetch_valid    (fetch_valid),
        .fetch_inst     (fetch_inst),
        .fetch_pc       (fetch_pc),
        .fetch_full     (fetch_full),
        .queue_is_empty (queue_is_empty),
        .queue_inst     (queue_inst),
        .queue_pc       (queue_pc),
        .decode_enable  (decode_enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [63:0] head;
        bit          mempty;
        mempty = (model_q.size() == 0);
        head   = mempty ? 64'd0 : model_q[0];
        check({tag, ".empty"}, 32'(queue_is_empty), 32'(mempty));
        check({tag, ".full"},  32'(fetch_full),     32'(model_q.size() == DEPTH));
        check({tag, ".inst"},  queue_inst,          head[63:32]);
        check({tag, ".pc"},    queue_pc,            head[31:0]);
    endtask

    // One clock cycle: drive on the falling edge, advance the model at the
    // rising edge, compare 1 time unit later.
    task automatic step(input bit r, input bit rd, input bit fl, input bit fv,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input bit de, input string tag);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        rst = r; rdy = rd; flush = fl; fetch_valid = fv;
        fetch_inst = inst; fetch_pc = pc; decode_enable = de;
        do_push = fv && (model_q.size() < DEPTH);
        do_pop  = de && (model_q.size() > 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
        end else if (rd) begin
            if (fl) begin
                model_q.delete();
            end else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back({inst, pc});
            end
        end
        #1;
        check_model(tag);
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc, input string tag);
        step(0, 1, 0, 1, inst, pc, 0, tag);
    endtask

    task automatic pop(input string tag);
        step(0, 1, 0, 0, 32'h0, 32'h0, 1, tag);
    endtask

    task automatic idle(input string tag);
        step(0, 1, 0, 0, 32'h0, 32'h0, 0, tag);
    endtask

    initial begin
        // Reset then idle, pops on empty are ignored
        step(1, 1, 0, 0, 32'h0, 32'h0, 0, "reset");
        check("reset.pc_zero", queue_pc, 32'h0);
        idle("idle");
        for (int i = 0; i < 3; i++) pop("pop_empty");
        check("pop_empty.still_empty", 32'(queue_is_empty), 32'd1);

        // Fill and drain
        for (int i = 0; i < DEPTH; i++)
            push(32'h13 + 32'(i), 32'h1000 + 32'(4 * i), "fill");
        check("fill.full", 32'(fetch_full), 32'd1);
        push(32'hDEAD, 32'h1040, "push_full");
        check("push_full.head_pc", queue_pc, 32'h1000);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain.pc_order", queue_pc, 32'h1000 + 32'(4 * i));
            pop("drain");
        end
        check("drain.empty", 32'(queue_is_empty), 32'd1);

        // Simultaneous push/pop with 3 held, across pointer wrap
        for (int i = 0; i < 3; i++) push(32'hA000 + 32'(i), 32'h3000 + 32'(4 * i), "pre3");
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 1, 32'hB000 + 32'(i), 32'h4000 + 32'(4 * i), 1, "pushpop");
        check("pushpop.head_pc", queue_pc, 32'h4000 + 32'(4 * 17));
        for (int i = 0; i < 3; i++) pop("drain3");
        step(0, 1, 0, 1, 32'hC0DE, 32'h5000, 1, "pushpop_empty");
        check("pushpop_empty.landed", queue_pc, 32'h5000);
        pop("drain1");

        // Flush beats push and pop
        for (int i = 0; i < 5; i++) push(32'hF000 + 32'(i), 32'h6000 + 32'(4 * i), "pre5");
        step(0, 1, 1, 1, 32'h1234, 32'h2000, 1, "flush");
        check("flush.empty", 32'(queue_is_empty), 32'd1);
        idle("post_flush");

        // rdy stall freezes everything
        push(32'h11, 32'h7000, "pre2");
        push(32'h22, 32'h7004, "pre2");
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, 32'h99, 32'h7777, 1, "stall");
        check("stall.head_pc", queue_pc, 32'h7000);
        pop("resume");
        check("resume.head_pc", queue_pc, 32'h7004);
        pop("resume");

        // Push on full with concurrent pop: only pop happens
        for (int i = 0; i < DEPTH; i++) push(32'h100 + 32'(i), 32'h8000 + 32'(4 * i), "fill2");
        step(0, 1, 0, 1, 32'hBEEF, 32'h9000, 1, "full_pushpop");
        check("full_pushpop.not_full", 32'(fetch_full), 32'd0);
        push(32'hBEEF, 32'h9000, "retry_push");
        check("retry_push.full", 32'(fetch_full), 32'd1);

        // Randomized phase, includes mid-operation resets
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 9) < 6),
                 $urandom, $urandom, ($urandom_range(0, 9) < 5), "random");
        end
        step(1, 0, 1, 1, 32'h1, 32'h1, 1, "final_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
